// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a table of 2-bit
// saturating counters, indexed bimodally or by gshare. Lookup is purely
// combinational on the fetch PC; training happens when a control
// instruction resolves in EX. Two saturating counters track resolved and
// mispredicted control instructions.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 5,
    parameter int GHR_BITS = 5,
    parameter int MODE     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     if_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_is_branch,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_mispredict,
    output logic [31:0]         stat_resolved,
    output logic [31:0]         stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam int TAG_W = XLEN - IDX_BITS - 2;

    logic [DEPTH-1:0]    btb_valid;
    logic [DEPTH-1:0]    btb_jump;
    logic [TAG_W-1:0]    btb_tag    [DEPTH];
    logic [XLEN-1:0]     btb_target [DEPTH];
    logic [1:0]          pht        [DEPTH];
    logic [GHR_BITS-1:0] ghr;

    logic [IDX_BITS-1:0] bidx;
    logic                hit;
    logic [XLEN-1:0]     pc_plus4;
    logic [IDX_BITS-1:0] upd_bidx;

    // Word-aligned PCs: the low two bits of the resolved PC carry no information.
    logic unused_upd_pc_lsbs;
    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    assign upd_bidx = upd_pc[IDX_BITS+1:2];

    // Lookup: BTB hit, PHT index and predicted next PC for the fetch PC.
    // During reset every valid bit is clear, so the lookup always misses and
    // falls through to PC+4 without needing reset in this path.
    always_comb begin
        bidx        = if_pc[IDX_BITS+1:2];
        hit         = btb_valid[bidx] && (btb_tag[bidx] == if_pc[XLEN-1:IDX_BITS+2]);
        pc_plus4    = if_pc + XLEN'(4);
        pred_idx    = bidx;
        pred_taken  = 1'b0;
        if (MODE == 2) begin
            pred_idx = bidx ^ IDX_BITS'(ghr);
        end
        if (MODE != 0) begin
            pred_taken = hit && (btb_jump[bidx] || pht[pred_idx][1]);
        end
        pred_target = pred_taken ? btb_target[bidx] : pc_plus4;
    end

    // BTB: taken outcomes allocate (or overwrite an aliasing entry);
    // not-taken branches leave the entry untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid <= '0;
            btb_jump  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_valid[upd_bidx]  <= 1'b1;
            btb_jump[upd_bidx]   <= !upd_is_branch;
            btb_tag[upd_bidx]    <= upd_pc[XLEN-1:IDX_BITS+2];
            btb_target[upd_bidx] <= upd_target;
        end
    end

    // PHT: train the counter selected at fetch time, saturating at 0 and 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (upd_valid && upd_is_branch) begin
            if (upd_taken && (pht[upd_idx] != 2'b11)) begin
                pht[upd_idx] <= pht[upd_idx] + 2'b01;
            end else if (!upd_taken && (pht[upd_idx] != 2'b00)) begin
                pht[upd_idx] <= pht[upd_idx] - 2'b01;
            end
        end
    end

    // GHR: shift in conditional-branch outcomes only, newest in bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (upd_valid && upd_is_branch) begin
            ghr <= (ghr << 1) | GHR_BITS'(upd_taken);
        end
    end

    // Statistics: saturating counts of resolved and mispredicted instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_resolved    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (stat_resolved != '1) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (upd_mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: three instances (always-not-taken, bimodal,
// gshare) share one stimulus stream and are compared against a table-level
// model of BTB, counters, history and statistics.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic [4:0]  upd_idx = 5'd0;
    logic        upd_is_branch = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_mispredict = 1'b0;

    logic        pt0, pt1, pt2;
    logic [31:0] tg0, tg1, tg2;
    logic [4:0]  ix0, ix1, ix2;
    logic [31:0] sr0, sr1, sr2, sm0, sm1, sm2;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_valid [32];
    bit          m_jump  [32];
    logic [31:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    int          m_pht   [32];
    int          m_ghr;
    int unsigned m_res, m_mis;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pt0), .pred_target(tg0), .pred_idx(ix0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
        .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_resolved(sr0), .stat_mispredicts(sm0));

    branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(1)) u_m1 (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pt1), .pred_target(tg1), .pred_idx(ix1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
        .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_resolved(sr1), .stat_mispredicts(sm1));

    branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(2)) u_m2 (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pt2), .pred_target(tg2), .pred_idx(ix2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
        .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_resolved(sr2), .stat_mispredicts(sm2));

    function automatic int bidx_of(logic [31:0] pc);
        return int'((pc >> 2) % 32);
    endfunction

    function automatic int exp_idx(int mode, logic [31:0] pc);
        return (mode == 2) ? (bidx_of(pc) ^ m_ghr) : bidx_of(pc);
    endfunction

    function automatic bit exp_taken(int mode, logic [31:0] pc);
        int b;
        b = bidx_of(pc);
        if (mode == 0) return 1'b0;
        if (!(m_valid[b] && m_tag[b] == (pc >> 7))) return 1'b0;
        return m_jump[b] || (m_pht[exp_idx(mode, pc)] >= 2);
    endfunction

    function automatic logic [31:0] exp_target(int mode, logic [31:0] pc);
        return exp_taken(mode, pc) ? m_tgt[bidx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_jump[i]  = 1'b0;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
            m_pht[i]   = 1;
        end
        m_ghr = 0;
        m_res = 0;
        m_mis = 0;
    endtask

    task automatic model_update();
        int b;
        if (!upd_valid) return;
        m_res++;
        if (upd_mispredict) m_mis++;
        b = bidx_of(upd_pc);
        if (upd_taken) begin
            m_valid[b] = 1'b1;
            m_tag[b]   = upd_pc >> 7;
            m_tgt[b]   = upd_target;
            m_jump[b]  = !upd_is_branch;
        end
        if (upd_is_branch) begin
            if (upd_taken) m_pht[upd_idx] = (m_pht[upd_idx] == 3) ? 3 : m_pht[upd_idx] + 1;
            else           m_pht[upd_idx] = (m_pht[upd_idx] == 0) ? 0 : m_pht[upd_idx] - 1;
            m_ghr = ((m_ghr << 1) | int'(upd_taken)) % 32;
        end
    endtask

    // Advance through one rising edge; the model sees the same inputs the DUT does.
    task automatic tick();
        @(posedge clk);
        if (reset) model_update();
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input int idx,
                           input logic br, input logic tk, input logic [31:0] tgt,
                           input logic mp);
        upd_valid      = v;
        upd_pc         = pc;
        upd_idx        = 5'(idx);
        upd_is_branch  = br;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    task automatic apply_reset();
        set_upd(1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        if_pc = 32'h100;
        set_upd(1'b1, 32'h40, 16, 1'b1, 1'b1, 32'h80, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (pt1 !== 1'b0 || pt2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_taken got m1=%0b m2=%0b want 0", pt1, pt2);
            end
            checks++;
            if (tg1 !== 32'h104 || tg2 !== 32'h104) begin
                failures++;
                $display("FAIL reset_target got m1=%h m2=%h want 00000104", tg1, tg2);
            end
            checks++;
            if (sr1 !== 32'd0 || sm1 !== 32'd0 || sr0 !== 32'd0) begin
                failures++;
                $display("FAIL reset_stats got res=%0d mis=%0d want 0", sr1, sm1);
            end
            tick();
        end
        @(negedge clk);
        upd_valid = 1'b0;
        reset = 1'b1;
        tick();
        if_pc = 32'h40;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b0 || pt2 !== 1'b0 || tg1 !== 32'h44) begin
            failures++;
            $display("FAIL reset_miss got taken=%0b/%0b target=%h want 0/0 00000044", pt1, pt2, tg1);
        end
        tick();
    endtask

    task automatic test_bimodal();
        set_upd(1'b1, 32'h40, 16, 1'b1, 1'b1, 32'h80, 1'b0);
        tick();
        upd_valid = 1'b0;
        if_pc = 32'h40;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b1 || tg1 !== 32'h80) begin
            failures++;
            $display("FAIL bimodal_train got taken=%0b target=%h want 1 00000080", pt1, tg1);
        end
        checks++;
        if (pt2 !== exp_taken(2, if_pc) || tg2 !== exp_target(2, if_pc)) begin
            failures++;
            $display("FAIL bimodal_gshare_side got taken=%0b target=%h want %0b %h",
                     pt2, tg2, exp_taken(2, if_pc), exp_target(2, if_pc));
        end
        tick();
        set_upd(1'b1, 32'h40, 16, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b0 || tg1 !== 32'h44) begin
            failures++;
            $display("FAIL bimodal_untrain got taken=%0b target=%h want 0 00000044", pt1, tg1);
        end
        tick();
    endtask

    task automatic test_jump();
        // history is 100 from the previous test: T, N, N
        set_upd(1'b1, 32'h10, 3, 1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        upd_valid = 1'b0;
        if_pc = 32'h10;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b1 || tg1 !== 32'h200 || pt2 !== 1'b1 || tg2 !== 32'h200) begin
            failures++;
            $display("FAIL jump_predict got m1=%0b/%h m2=%0b/%h want 1/00000200", pt1, tg1, pt2, tg2);
        end
        checks++;
        if (ix2 !== 5'd0 || pt0 !== 1'b0) begin
            failures++;
            $display("FAIL jump_ghr got idx=%0d m0taken=%0b want 0 0", ix2, pt0);
        end
        tick();
        if_pc = 32'h40;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b0 || ix2 !== 5'd20) begin
            failures++;
            $display("FAIL jump_pht got taken=%0b idx=%0d want 0 20", pt1, ix2);
        end
        tick();
    endtask

    task automatic test_alias();
        set_upd(1'b1, 32'h40, 16, 1'b1, 1'b1, 32'h80, 1'b0);
        tick();
        tick();
        upd_valid = 1'b0;
        if_pc = 32'hC0;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b0 || tg1 !== 32'hC4 || pt2 !== 1'b0) begin
            failures++;
            $display("FAIL alias got taken=%0b target=%h want 0 000000c4", pt1, tg1);
        end
        tick();
        if_pc = 32'h40;
        @(negedge clk);
        checks++;
        if (pt1 !== 1'b1 || tg1 !== 32'h80) begin
            failures++;
            $display("FAIL alias_owner got taken=%0b target=%h want 1 00000080", pt1, tg1);
        end
        tick();
    endtask

    task automatic test_gshare();
        apply_reset();
        set_upd(1'b1, 32'h20, 8, 1'b1, 1'b1, 32'h300, 1'b0);
        repeat (3) tick();
        upd_valid = 1'b0;
        if_pc = 32'h40;
        @(negedge clk);
        checks++;
        if (ix2 !== 5'd23 || ix1 !== 5'd16 || ix0 !== 5'd16) begin
            failures++;
            $display("FAIL gshare_idx got m2=%0d m1=%0d m0=%0d want 23 16 16", ix2, ix1, ix0);
        end
        tick();
        set_upd(1'b1, 32'h10, 0, 1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ix2 !== 5'd23) begin
            failures++;
            $display("FAIL gshare_jump_ghr got idx=%0d want 23", ix2);
        end
        tick();
    endtask

    task automatic test_stats();
        bit mp_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            set_upd(1'b1, 32'h100, 0, 1'b1, 1'b0, 32'h0, mp_pat[k]);
            tick();
        end
        upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sr1 !== 32'd5 || sm1 !== 32'd2 || sr0 !== 32'd5 || sm0 !== 32'd2) begin
            failures++;
            $display("FAIL stats_count got res=%0d mis=%0d (m0 %0d %0d) want 5 2", sr1, sm1, sr0, sm0);
        end
        tick();
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (sr1 !== 32'd0 || sm1 !== 32'd0 || sr2 !== 32'd0 || sm2 !== 32'd0) begin
            failures++;
            $display("FAIL stats_async_reset got res=%0d mis=%0d want 0 0", sr1, sm1);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [8];
        for (int i = 0; i < 8; i++) begin
            pcs[i] = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 31)) << 2);
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) if_pc = 32'hFFFF_FFFC;
            else                            if_pc = pcs[$urandom_range(0, 7)];
            set_upd($urandom_range(0, 3) != 0, pcs[$urandom_range(0, 7)],
                    int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                    1'($urandom), {$urandom_range(0, 1023), 2'b00}, 1'($urandom));
            if (upd_valid && !upd_is_branch) upd_taken = 1'b1;
            @(negedge clk);
            checks++;
            if (pt1 !== exp_taken(1, if_pc) || tg1 !== exp_target(1, if_pc) || ix1 !== 5'(exp_idx(1, if_pc))) begin
                failures++;
                $display("FAIL rand_bimodal n=%0d pc=%h got %0b/%h/%0d want %0b/%h/%0d", n, if_pc,
                         pt1, tg1, ix1, exp_taken(1, if_pc), exp_target(1, if_pc), exp_idx(1, if_pc));
            end
            checks++;
            if (pt2 !== exp_taken(2, if_pc) || tg2 !== exp_target(2, if_pc) || ix2 !== 5'(exp_idx(2, if_pc))) begin
                failures++;
                $display("FAIL rand_gshare n=%0d pc=%h got %0b/%h/%0d want %0b/%h/%0d", n, if_pc,
                         pt2, tg2, ix2, exp_taken(2, if_pc), exp_target(2, if_pc), exp_idx(2, if_pc));
            end
            checks++;
            if (pt0 !== 1'b0 || tg0 !== if_pc + 32'd4) begin
                failures++;
                $display("FAIL rand_static n=%0d got %0b/%h want 0/%h", n, pt0, tg0, if_pc + 32'd4);
            end
            checks++;
            if (sr2 !== m_res || sm2 !== m_mis || sr0 !== m_res) begin
                failures++;
                $display("FAIL rand_stats n=%0d got %0d/%0d want %0d/%0d", n, sr2, sm2, m_res, m_mis);
            end
            tick();
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bimodal();
        test_jump();
        test_alias();
        test_gshare();
        test_stats();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined RV32I core. Replaces fixed "predict PC+4" fetch with a direct-mapped BTB and a 2-bit-counter PHT indexed bimodally or by gshare. It sits beside the IF stage:

- **Lookup:** combinational on the fetch PC.
- **Update:** at resolution in EX, with the PHT index carried down the pipeline.
- **Statistics:** saturating counters for resolved and mispredicted control instructions.

## Interface
- `XLEN`, default 32: PC/target width.
- `IDX_BITS`, default 5: BTB/PHT depth = 2^IDX_BITS entries. Index = `pc[IDX_BITS+1:2]`.
- `GHR_BITS`, default 5: global history length. Must satisfy 1 ≤ `GHR_BITS` ≤ `IDX_BITS`.
- `MODE`, default 2: 0 = always-not-taken, 1 = bimodal, 2 = gshare.
- `clk` in 1: single clock. All state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_pc` in XLEN: PC currently being fetched.
- `pred_taken` out 1: predicted taken.
- `pred_target` out XLEN: predicted next PC.
- `pred_idx` out IDX_BITS: PHT index used for this lookup. Pipelined to EX by the core.
- `upd_valid` in 1: a control instruction resolved this cycle.
- `upd_pc` in XLEN: PC of the resolved instruction.
- `upd_idx` in IDX_BITS: `pred_idx` captured when that instruction was fetched.
- `upd_is_branch` in 1: 1 = conditional branch, 0 = JAL/JALR.
- `upd_taken` in 1: actual outcome. Jumps are always 1.
- `upd_target` in XLEN: actual target.
- `upd_mispredict` in 1: core-detected mispredict of this instruction.
- `stat_resolved` out 32: count of `upd_valid` cycles.
- `stat_mispredicts` out 32: count of `upd_valid && upd_mispredict` cycles.

## Operation
**State**
- BTB entry: valid, tag = `pc[XLEN-1:IDX_BITS+2]`, target, is_jump.
- PHT: 2^IDX_BITS 2-bit saturating counters.
- GHR: GHR_BITS bits, newest outcome in bit 0.

**Lookup (combinational)**
- `bidx` = `if_pc[IDX_BITS+1:2]`.
- hit = valid[bidx] && tag match.
- `pred_idx` = `bidx` in MODE 0/1; `bidx ^ zero-extended GHR` in MODE 2.
- `pred_taken` = (MODE≠0) && hit && (is_jump[bidx] || PHT[pred_idx][1]).
- `pred_target` = `pred_taken` ? BTB target : `if_pc`+4. The +4 wraps modulo 2^XLEN.

**Update (rising edge, `upd_valid`=1)**
- BTB at `upd_pc` index:
  - if `upd_taken`, write valid=1, tag, `upd_target`, is_jump=!`upd_is_branch`. This overwrites any aliasing entry.
  - Not-taken branches never allocate or invalidate.
- PHT: only if `upd_is_branch`. Counter at `upd_idx` increments if taken, decrements otherwise, saturating at 0 and 3.
- GHR: only if `upd_is_branch`, GHR <= {GHR[GHR_BITS-2:0], `upd_taken`}. Jumps never shift the GHR.
- Stats:
  - `stat_resolved` +1 on every `upd_valid` cycle.
  - `stat_mispredicts` +1 when `upd_mispredict` is also set.
  - Both saturate at 0xFFFFFFFF.
- MODE 0: BTB/PHT/GHR may be left unused, but stats still count.
- `upd_valid`=0: no state changes. `upd_*` are don't-care.

**Reset**
- Asserting `reset` low, at any time including mid-update, immediately sets:
  - all BTB valid bits = 0,
  - all PHT counters = 01 (weakly not-taken),
  - GHR = 0,
  - both stats = 0.
- While `reset` is low, `pred_taken`=0, `pred_target`=`if_pc`+4, and updates are ignored.
- Normal operation starts on the first rising edge after `reset` goes high.

## Timing
- Lookup latency 0: outputs follow `if_pc` in the same cycle.
- Update latency 1: state written at the edge ending the `upd_valid` cycle. Visible to lookups in the next cycle.
- Simultaneous lookup and update of the same entry: the lookup sees the pre-update value.
- Back-to-back updates every cycle: each one is applied in order.
- Each counter and the GHR updates at most once per cycle. `upd_idx` is used verbatim, never recomputed from the current GHR.

## Test plan
1. **Reset.** Hold `reset`=0, `if_pc`=0x100, pulse `upd_valid` with taken 0x40→0x80.
   - While held: `pred_taken`=0, `pred_target`=0x104, stats=0.
   - After release: a lookup of 0x40 misses.
2. **Bimodal training** (MODE=1). Update branch 0x40 taken→0x80 once.
   - Next cycle, `if_pc`=0x40: `pred_taken`=1, target 0x80 (counter 10).
   - After two not-taken updates: counter 00, `pred_taken`=0, target 0x44.
3. **Jump.** Update JAL 0x10→0x200.
   - Next cycle, `if_pc`=0x10: `pred_taken`=1, target 0x200.
   - GHR and PHT unchanged.
4. **Tag alias** (IDX_BITS=5). After training 0x40, look up 0xC0 (same index, different tag): `pred_taken`=0, target 0xC4.
5. **Gshare** (MODE=2, GHR_BITS=5). Three taken branch updates.
   - GHR=00111.
   - `if_pc`=0x40 gives `pred_idx`=16^7=23.
   - A jump update leaves GHR=00111.
6. **Stats and reset mid-stream.**
   - 5 updates, 2 with `upd_mispredict`: `stat_resolved`=5, `stat_mispredicts`=2.
   - Asynchronous reset pulse between edges zeroes both immediately, with no clock edge needed.
